// File: rtl/ibus_prefetch_buffer_pkg.sv
// Shared types for the instruction-bus prefetch buffer.
// FIFO entries pair a fetch address with its instruction word.
package ibus_prefetch_buffer_pkg;

   localparam int unsigned IBUF_ENTRY_ADDR_W = 64;
   localparam int unsigned IBUF_DATA_W       = 32;

   typedef struct packed {
      logic [IBUF_ENTRY_ADDR_W-1:0] addr;
      logic [IBUF_DATA_W-1:0]       data;
   } ibuf_entry_t;

   typedef enum logic [1:0] {
      IBUF_IDLE,
      IBUF_BUSY,
      IBUF_STALE
   } ibuf_state_t;

endpackage

// File: rtl/ibus_prefetch_buffer_fifo.sv
// Prefetch FIFO of {addr, data} entries with flush.
// Flush has priority over push and pop in the same cycle.
module ibuf_fifo
   import ibus_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  ibuf_entry_t              push_entry,
   input  logic                     pop,
   input  logic                     flush,
   output ibuf_entry_t              head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   ibuf_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push_ok) mem_q[wr_ptr_q] <= push_entry;
      end
   end

endmodule

// File: rtl/ibus_prefetch_buffer.sv
// Sequential instruction prefetch buffer: serves core fetches from a FIFO of
// prefetched words, redirecting and refilling on a miss. One memory request in flight.
module ibus_prefetch_buffer
   import ibus_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     core_valid,
   input  logic [ADDR_W-1:0]        core_addr,
   output logic                     core_data_ok,
   output logic [31:0]              core_data,
   output logic                     mem_valid,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_data_ok,
   input  logic [31:0]              mem_data,
   output logic [$clog2(DEPTH):0]   count
);

   ibuf_state_t        state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic               pc_valid_q, pc_valid_d;
   logic               mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;

   ibuf_entry_t        head;
   ibuf_entry_t        push_entry;
   logic               fifo_full, fifo_empty;
   logic               push, pop, flush;
   logic               head_match, hit, bypass, redirect, issue;

   ibuf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .head       (head),
      .count      (count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign mem_valid  = mem_valid_q;
   assign mem_addr   = mem_addr_q;
   assign push_entry = '{addr: IBUF_ENTRY_ADDR_W'(mem_addr_q), data: mem_data};

   // Request classification; hit and bypass are mutually exclusive via FIFO emptiness.
   assign head_match = !fifo_empty && (ADDR_W'(head.addr) == core_addr);
   assign hit        = core_valid && head_match;
   assign bypass     = core_valid && fifo_empty && (state_q == IBUF_BUSY) &&
                       (mem_addr_q == core_addr) && mem_data_ok;
   assign redirect   = core_valid && !hit && !bypass &&
                       ((!fifo_empty && !head_match) ||
                        (fifo_empty && (state_q == IBUF_IDLE) &&
                         (!pc_valid_q || (fetch_pc_q != core_addr))) ||
                        ((state_q == IBUF_BUSY) && (mem_addr_q != core_addr)));
   assign issue      = (state_q == IBUF_IDLE) && pc_valid_q && !fifo_full && !redirect;

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      pc_valid_d   = pc_valid_q;
      mem_valid_d  = mem_valid_q;
      mem_addr_d   = mem_addr_q;
      push         = 1'b0;
      pop          = 1'b0;
      flush        = 1'b0;
      core_data_ok = 1'b0;
      core_data    = '0;

      if (hit) begin
         core_data_ok = 1'b1;
         core_data    = head.data;
         pop          = 1'b1;
      end else if (bypass) begin
         core_data_ok = 1'b1;
         core_data    = mem_data;
      end

      if (redirect) begin
         flush      = 1'b1;
         fetch_pc_d = core_addr;
         pc_valid_d = 1'b1;
      end

      case (state_q)
         IBUF_IDLE: begin
            if (issue) begin
               state_d     = IBUF_BUSY;
               mem_valid_d = 1'b1;
               mem_addr_d  = fetch_pc_q;
            end
         end
         IBUF_BUSY: begin
            // A redirect in the response cycle drops the word but keeps the new PC.
            if (mem_data_ok) begin
               state_d     = IBUF_IDLE;
               mem_valid_d = 1'b0;
               if (!redirect) begin
                  fetch_pc_d = mem_addr_q + ADDR_W'(4);
                  push       = !bypass;
               end
            end else if (redirect) begin
               state_d = IBUF_STALE;
            end
         end
         IBUF_STALE: begin
            if (mem_data_ok) begin
               state_d     = IBUF_IDLE;
               mem_valid_d = 1'b0;
            end
         end
         default: state_d = IBUF_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IBUF_IDLE;
         fetch_pc_q  <= '0;
         pc_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         pc_valid_q  <= pc_valid_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

endmodule
